// File: rtl/calc2.sv
// calc2: four-port tagged calculator with a shared add/sub unit and an optional
// shift unit (enabled by defining CALC2_SHIFT_EN), round-robin arbitrated per unit.
package calc2_pkg;
  localparam int NP = 4;

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  localparam logic [1:0] RSP_IDLE = 2'd0;
  localparam logic [1:0] RSP_OK   = 2'd1;
  localparam logic [1:0] RSP_ERR  = 2'd2;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [1:0]  tag;
  } req_t;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
    logic [1:0]  tag;
  } rsp_t;

  // Everything that is not a shift lands here, so unknown cmds fall to RSP_ERR.
  function automatic rsp_t addsub_exec(input req_t r);
    rsp_t        o;
    logic [32:0] sum;
    o      = '0;
    o.tag  = r.tag;
    o.resp = RSP_ERR;
    sum    = {1'b0, r.op1} + {1'b0, r.op2};
    case (r.cmd)
      CMD_ADD: if (!sum[32]) begin
        o.resp = RSP_OK;
        o.data = sum[31:0];
      end
      CMD_SUB: if (r.op2 <= r.op1) begin
        o.resp = RSP_OK;
        o.data = r.op1 - r.op2;
      end
      default: ;
    endcase
    return o;
  endfunction

`ifdef CALC2_SHIFT_EN
  function automatic rsp_t shift_exec(input req_t r);
    rsp_t o;
    o      = '0;
    o.tag  = r.tag;
    o.resp = RSP_OK;
    o.data = (r.cmd == CMD_SHL) ? (r.op1 << r.op2[4:0]) : (r.op1 >> r.op2[4:0]);
    return o;
  endfunction
`endif
endpackage

module calc2_port
  import calc2_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [3:0]  cmd_in,
  input  logic [31:0] data_in,
  input  logic [1:0]  tag_in,
  input  logic        pop,
  output logic        hvld,
  output req_t        head
);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  typedef enum logic {S_IDLE, S_OP2} state_e;
  state_e state_q, state_d;
  logic   cap, push;

  logic [3:0]  cmd_q;
  logic [31:0] op1_q;
  logic [1:0]  tag_q;

  always_ff @(posedge c_clk or negedge reset)
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;

  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    push    = 1'b0;
    case (state_q)
      S_IDLE: if (cmd_in != CMD_NOP) begin
        cap     = 1'b1;
        state_d = S_OP2;
      end
      S_OP2: begin
        push    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge c_clk or negedge reset)
    if (!reset) begin
      cmd_q <= '0;
      op1_q <= '0;
      tag_q <= '0;
    end else if (cap) begin
      cmd_q <= cmd_in;
      op1_q <= data_in;
      tag_q <= tag_in;
    end

  req_t          mem [QDEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic          full, wr, rd;

  assign full = (cnt == CW'(QDEPTH));
  assign hvld = (cnt != '0);
  assign head = mem[rp];
  // Fullness is judged before the same-edge pop: a push into a full queue drops.
  assign wr   = push & ~full;
  assign rd   = pop & hvld;

  always_ff @(posedge c_clk)
    if (wr) mem[wp] <= '{cmd: cmd_q, op1: op1_q, op2: data_in, tag: tag_q};

  always_ff @(posedge c_clk or negedge reset)
    if (!reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= (wp == PW'(QDEPTH - 1)) ? '0 : wp + 1'b1;
      if (rd) rp <= (rp == PW'(QDEPTH - 1)) ? '0 : rp + 1'b1;
      cnt <= cnt + CW'(wr) - CW'(rd);
    end
endmodule

module calc2_rr #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic          c_clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  output logic          gvld,
  output logic [IW-1:0] gidx
);
  logic [IW-1:0] ptr;

  always_comb begin
    gvld = 1'b0;
    gidx = ptr;
    for (int i = 0; i < N; i++)
      if (!gvld && req[(int'(ptr) + i) % N]) begin
        gvld = 1'b1;
        gidx = IW'((int'(ptr) + i) % N);
      end
  end

  always_ff @(posedge c_clk or negedge reset)
    if (!reset)    ptr <= '0;
    else if (gvld) ptr <= (gidx == IW'(N - 1)) ? '0 : gidx + 1'b1;
endmodule

module calc2
  import calc2_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [3:0]  req1_cmd_in,
  input  logic [31:0] req1_data_in,
  input  logic [1:0]  req1_tag_in,
  input  logic [3:0]  req2_cmd_in,
  input  logic [31:0] req2_data_in,
  input  logic [1:0]  req2_tag_in,
  input  logic [3:0]  req3_cmd_in,
  input  logic [31:0] req3_data_in,
  input  logic [1:0]  req3_tag_in,
  input  logic [3:0]  req4_cmd_in,
  input  logic [31:0] req4_data_in,
  input  logic [1:0]  req4_tag_in,
  output logic [1:0]  out_resp1,
  output logic [31:0] out_data1,
  output logic [1:0]  out_tag1,
  output logic [1:0]  out_resp2,
  output logic [31:0] out_data2,
  output logic [1:0]  out_tag2,
  output logic [1:0]  out_resp3,
  output logic [31:0] out_data3,
  output logic [1:0]  out_tag3,
  output logic [1:0]  out_resp4,
  output logic [31:0] out_data4,
  output logic [1:0]  out_tag4
);
  logic [NP-1:0][3:0]  cmd_in;
  logic [NP-1:0][31:0] data_in;
  logic [NP-1:0][1:0]  tag_in;

  assign cmd_in  = {req4_cmd_in,  req3_cmd_in,  req2_cmd_in,  req1_cmd_in};
  assign data_in = {req4_data_in, req3_data_in, req2_data_in, req1_data_in};
  assign tag_in  = {req4_tag_in,  req3_tag_in,  req2_tag_in,  req1_tag_in};

  req_t          head [NP];
  logic [NP-1:0] hvld, pop, as_req;

  for (genvar p = 0; p < NP; p++) begin : g_port
    calc2_port #(.QDEPTH(QDEPTH)) u_port (
      .c_clk   (c_clk),
      .reset   (reset),
      .cmd_in  (cmd_in[p]),
      .data_in (data_in[p]),
      .tag_in  (tag_in[p]),
      .pop     (pop[p]),
      .hvld    (hvld[p]),
      .head    (head[p])
    );
  end

  logic       as_gvld, as_vld;
  logic [1:0] as_gidx, as_port;
  req_t       as_q;

`ifdef CALC2_SHIFT_EN
  logic [NP-1:0] sh_req;
  logic          sh_gvld, sh_vld;
  logic [1:0]    sh_gidx, sh_port;
  req_t          sh_q;

  always_comb begin
    as_req = '0;
    sh_req = '0;
    for (int p = 0; p < NP; p++) begin
      sh_req[p] = hvld[p] & ((head[p].cmd == CMD_SHL) || (head[p].cmd == CMD_SHR));
      as_req[p] = hvld[p] & ~sh_req[p];
    end
  end

  calc2_rr #(.N(NP)) u_sh_arb (
    .c_clk (c_clk),
    .reset (reset),
    .req   (sh_req),
    .gvld  (sh_gvld),
    .gidx  (sh_gidx)
  );

  always_ff @(posedge c_clk or negedge reset)
    if (!reset) begin
      sh_vld  <= 1'b0;
      sh_port <= '0;
      sh_q    <= '0;
    end else begin
      sh_vld <= sh_gvld;
      if (sh_gvld) begin
        sh_port <= sh_gidx;
        sh_q    <= head[sh_gidx];
      end
    end
`else
  assign as_req = hvld;
`endif

  calc2_rr #(.N(NP)) u_as_arb (
    .c_clk (c_clk),
    .reset (reset),
    .req   (as_req),
    .gvld  (as_gvld),
    .gidx  (as_gidx)
  );

  // A port's head feeds exactly one unit, so at most one pop per port per cycle.
  always_comb begin
    pop = '0;
    if (as_gvld) pop[as_gidx] = 1'b1;
`ifdef CALC2_SHIFT_EN
    if (sh_gvld) pop[sh_gidx] = 1'b1;
`endif
  end

  always_ff @(posedge c_clk or negedge reset)
    if (!reset) begin
      as_vld  <= 1'b0;
      as_port <= '0;
      as_q    <= '0;
    end else begin
      as_vld <= as_gvld;
      if (as_gvld) begin
        as_port <= as_gidx;
        as_q    <= head[as_gidx];
      end
    end

  rsp_t [NP-1:0] rsp_q;

  always_ff @(posedge c_clk or negedge reset)
    if (!reset) rsp_q <= '0;
    else
      for (int p = 0; p < NP; p++) begin
        rsp_q[p] <= '0;
        if (as_vld && as_port == 2'(p)) rsp_q[p] <= addsub_exec(as_q);
`ifdef CALC2_SHIFT_EN
        if (sh_vld && sh_port == 2'(p)) rsp_q[p] <= shift_exec(sh_q);
`endif
      end

  assign out_resp1 = rsp_q[0].resp;
  assign out_data1 = rsp_q[0].data;
  assign out_tag1  = rsp_q[0].tag;
  assign out_resp2 = rsp_q[1].resp;
  assign out_data2 = rsp_q[1].data;
  assign out_tag2  = rsp_q[1].tag;
  assign out_resp3 = rsp_q[2].resp;
  assign out_data3 = rsp_q[2].data;
  assign out_tag3  = rsp_q[2].tag;
  assign out_resp4 = rsp_q[3].resp;
  assign out_data4 = rsp_q[3].data;
  assign out_tag4  = rsp_q[3].tag;
endmodule

// File: tb/tb_calc2.sv
// Scoreboard bench for calc2: per-port expected-response queues filled at issue,
// drained by a negedge monitor; directed cases followed by randomized traffic.
module tb_calc2;
  localparam int QDEPTH = 4;

  logic        c_clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  cmd [4];
  logic [31:0] dat [4];
  logic [1:0]  tg  [4];
  logic [1:0]  resp [4];
  logic [31:0] odat [4];
  logic [1:0]  otag [4];

  typedef struct {
    logic [1:0]  r;
    logic [31:0] d;
    logic [1:0]  t;
  } exp_t;

  exp_t q [4][$];
  exp_t me;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   rcyc [4];

  calc2 #(.QDEPTH(QDEPTH)) dut (
    .c_clk        (c_clk),
    .reset        (reset),
    .req1_cmd_in  (cmd[0]), .req1_data_in (dat[0]), .req1_tag_in (tg[0]),
    .req2_cmd_in  (cmd[1]), .req2_data_in (dat[1]), .req2_tag_in (tg[1]),
    .req3_cmd_in  (cmd[2]), .req3_data_in (dat[2]), .req3_tag_in (tg[2]),
    .req4_cmd_in  (cmd[3]), .req4_data_in (dat[3]), .req4_tag_in (tg[3]),
    .out_resp1    (resp[0]), .out_data1 (odat[0]), .out_tag1 (otag[0]),
    .out_resp2    (resp[1]), .out_data2 (odat[1]), .out_tag2 (otag[1]),
    .out_resp3    (resp[2]), .out_data3 (odat[2]), .out_tag3 (otag[2]),
    .out_resp4    (resp[3]), .out_data4 (odat[3]), .out_tag4 (otag[3])
  );

  always #5 c_clk = ~c_clk;
  always @(posedge c_clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic on 64-bit values.
  function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                 input logic [1:0] t);
    exp_t            e;
    longint unsigned s;
    e.t = t;
    e.r = 2'd2;
    e.d = 32'd0;
    case (c)
      4'd1: begin
        s = 64'(a) + 64'(b);
        if (s <= 64'h0000_0000_FFFF_FFFF) begin e.r = 2'd1; e.d = s[31:0]; end
      end
      4'd2: if (a >= b) begin e.r = 2'd1; e.d = a - b; end
`ifdef CALC2_SHIFT_EN
      4'd5: begin e.r = 2'd1; e.d = a << (b % 32); end
      4'd6: begin e.r = 2'd1; e.d = a >> (b % 32); end
`endif
      default: ;
    endcase
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge c_clk)
    if (reset)
      for (int p = 0; p < 4; p++) begin
        if (resp[p] != 2'd0) begin
          rcyc[p] = cyc;
          if (q[p].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_resp port%0d: got resp %0d data %0h tag %0d expected none",
                     p + 1, resp[p], odat[p], otag[p]);
          end else begin
            me = q[p].pop_front();
            check($sformatf("resp_p%0d", p + 1), 32'(resp[p]), 32'(me.r));
            check($sformatf("data_p%0d", p + 1), odat[p], me.d);
            check($sformatf("tag_p%0d", p + 1), 32'(otag[p]), 32'(me.t));
          end
        end else begin
          check($sformatf("idle_data_p%0d", p + 1), odat[p], 32'd0);
          check($sformatf("idle_tag_p%0d", p + 1), 32'(otag[p]), 32'd0);
        end
      end

  // Caller is at posedge+1; returns at posedge+1 just after the operand-2 edge.
  task automatic issue(input int p, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [1:0] t);
    q[p].push_back(model(c, a, b, t));
    cmd[p] = c;
    dat[p] = a;
    tg[p]  = t;
    @(posedge c_clk); #1;
    cmd[p] = 4'($urandom_range(0, 15));
    dat[p] = b;
    tg[p]  = 2'($urandom);
    @(posedge c_clk); #1;
    cmd[p] = 4'd0;
    dat[p] = $urandom;
    tg[p]  = 2'd0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((q[0].size() + q[1].size() + q[2].size() + q[3].size()) != 0 && n < 300) begin
      @(posedge c_clk); #1;
      n++;
    end
    tests++;
    if (n >= 300) begin
      fails++;
      $display("FAIL %s: got %0d pending responses expected 0 (timeout)", name,
               q[0].size() + q[1].size() + q[2].size() + q[3].size());
      for (int p = 0; p < 4; p++) q[p].delete();
    end
    repeat (2) begin @(posedge c_clk); #1; end
  endtask

  task automatic check_all_zero(input string name);
    for (int p = 0; p < 4; p++) begin
      check($sformatf("%s_resp_p%0d", name, p + 1), 32'(resp[p]), 32'd0);
      check($sformatf("%s_data_p%0d", name, p + 1), odat[p], 32'd0);
      check($sformatf("%s_tag_p%0d", name, p + 1), 32'(otag[p]), 32'd0);
    end
  endtask

  function automatic logic [3:0] pick_cmd();
    case ($urandom_range(0, 7))
      0, 1:    return 4'd1;
      2, 3:    return 4'd2;
      4:       return 4'd5;
      5:       return 4'd6;
      6:       return 4'($urandom_range(7, 15));
      default: return 4'($urandom_range(3, 4));
    endcase
  endfunction

  task automatic rand_port(input int p, input int n);
    logic [31:0] a, b;
    logic [3:0]  c;
    repeat (n) begin
      repeat ($urandom_range(0, 2)) begin @(posedge c_clk); #1; end
      if (q[p].size() < QDEPTH) begin
        c = pick_cmd();
        a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
        b = ($urandom_range(0, 3) == 0) ? a - 32'($urandom_range(0, 3)) : $urandom;
        issue(p, c, a, b, 2'($urandom));
      end else begin
        @(posedge c_clk); #1;
      end
    end
  endtask

  int t0;

  initial begin
    for (int p = 0; p < 4; p++) begin
      cmd[p] = 4'd0; dat[p] = 32'd0; tg[p] = 2'd0; rcyc[p] = -1;
    end
    repeat (3) begin @(posedge c_clk); #1; end
    check_all_zero("reset");
    reset = 1'b1;
    @(posedge c_clk); #1;

    // Uncontended latency: response seen exactly 4 cycle-counts after drive time.
    t0 = cyc;
    issue(0, 4'd1, 32'h30, 32'h20, 2'd1);
    wait_drain("drain_add");
    check("lat_p1", 32'(rcyc[0]), 32'(t0 + 4));

    issue(1, 4'd1, 32'hFFFF_FFFF, 32'h1, 2'd2);
    wait_drain("drain_ovf");
    issue(2, 4'd2, 32'd5, 32'd6, 2'd3);
    issue(2, 4'd2, 32'd6, 32'd5, 2'd0);
    wait_drain("drain_sub");
    issue(3, 4'd5, 32'h1, 32'h21, 2'd1);
    issue(3, 4'd6, 32'h8000_0000, 32'd31, 2'd1);
    wait_drain("drain_shift");
    issue(0, 4'hF, 32'h1234, 32'h5678, 2'd2);
    wait_drain("drain_inv");

    // Fresh arbiter pointers, then all four ports collide on the add unit.
    reset = 1'b0;
    @(posedge c_clk); #1;
    reset = 1'b1;
    for (int p = 0; p < 4; p++) rcyc[p] = -1;
    t0 = cyc;
    fork
      issue(0, 4'd1, 32'h100, 32'h1, 2'd0);
      issue(1, 4'd1, 32'h200, 32'h2, 2'd1);
      issue(2, 4'd1, 32'h300, 32'h3, 2'd2);
      issue(3, 4'd1, 32'h400, 32'h4, 2'd3);
    join
    wait_drain("drain_contend");
    for (int p = 0; p < 4; p++)
      check($sformatf("contend_cyc_p%0d", p + 1), 32'(rcyc[p]), 32'(t0 + 4 + p));

    for (int p = 0; p < 4; p++) begin
      automatic int pp = p;
      fork
        rand_port(pp, 60);
      join_none
    end
    wait fork;
    wait_drain("drain_random");

    // Reset with a request sitting in the port-1 queue: it must vanish.
    rcyc[0] = -1;
    issue(0, 4'd1, 32'd5, 32'd6, 2'd2);
    reset = 1'b0;
    for (int p = 0; p < 4; p++) q[p].delete();
    @(posedge c_clk); #1;
    check_all_zero("midreset");
    reset = 1'b1;
    repeat (10) begin @(posedge c_clk); #1; end
    check("midreset_noresp", 32'(rcyc[0]), 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/calc2.md
# calc2

Four-port, tagged integer calculator sitting between four independent requesters and a shared pair of ALU units: one add/sub unit and one shift unit. Each port issues two-cycle requests: command, operand 1 and tag, then operand 2. Requests are queued per port and arbitrated round-robin onto the units. Each port gets back a one-cycle response carrying a status code, the 32-bit result and the request's tag.

## Interface
Parameters:
- QDEPTH, 4, per-port request FIFO depth.

Ports (n = 1..4):
- c_clk  input  1  single clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- reqn_cmd_in  input  4  command: 0 no-op, 1 add, 2 sub, 5 shift left, 6 shift right; others invalid.
- reqn_data_in  input  32  operand 1 in command cycle, operand 2 in following cycle.
- reqn_tag_in  input  2  requester tag, sampled in command cycle.
- out_respn  output  2  0 idle, 1 success, 2 overflow/underflow/invalid command; 3 never driven.
- out_datan  output  32  result; 0 when resp is not 1.
- out_tagn  output  2  tag of the answered request; 0 when idle.

## Operation
- Per-port capture FSM, two states:
  - IDLE: cmd != 0 latches cmd, operand 1 and tag, then moves to OP2.
  - OP2: latches operand 2 (cmd and tag ignored this cycle), pushes {cmd, op1, op2, tag} into the port FIFO, returns to IDLE.
- FIFO full at push: request silently dropped; no response.
- Each cycle the head of each non-empty FIFO requests its unit:
  - cmds 1, 2 and invalid cmds go to add/sub.
  - cmds 5, 6 go to shift.
- Each unit grants one port per cycle, round-robin. Pointer resets to port 1 and advances to the port after the granted one. The granted head is popped.
- Add: 33-bit sum; carry out gives resp 2, data 0; else resp 1, 32-bit sum.
- Sub: op2 > op1 (unsigned) gives resp 2, data 0; else resp 1, op1 - op2.
- Shift: amount = op2[4:0], logical, zero fill; always resp 1.
- Invalid cmd: resp 2, data 0.
- Tags are not checked for uniqueness; reused tags are passed through unchanged.
- Responses per port are returned in request order.

## Timing
- Reset value of every output: 0. Reset mid-operation clears FSMs, FIFOs, pipeline and arbiter pointers immediately. In-flight requests are lost and produce no response.
- Edge E0 samples cmd; E1 samples op2 and enqueues; E2 grants and issues; E3 registers the response.
- Uncontended latency: response valid from E3 to E4, exactly one cycle; outputs return to 0 after it.
- Both units have identical latency, so at most one response per port per cycle.
- Contention: a losing port's head waits, stalling later requests of that port (head-of-line blocking).
- Back-to-back requests on one port are allowed: a new cmd in the cycle right after OP2 is accepted.
- A nonzero cmd sampled while in OP2 is treated as operand-2 cycle data only.

## Configuration
- CALC2_SHIFT_EN defined: shift unit present; cmds 5 and 6 executed as above.
- CALC2_SHIFT_EN undefined: no shift unit. Cmds 5 and 6 are invalid: routed to add/sub, resp 2, data 0.

## Test plan
- Port 1 add, op1 0x30, op2 0x20, tag 1 → out_resp1 1, out_data1 0x50, out_tag1 1, valid exactly one cycle, 3 edges after cmd sampled; other ports stay 0.
- Port 2 add 0xFFFFFFFF + 1, tag 2 → resp 2, data 0, tag 2. Port 3 sub 5 - 6 → resp 2, data 0. Port 3 sub 6 - 5 → resp 1, data 1.
- Port 4 shl 0x1 by 0x21, then shr 0x80000000 by 31 → data 0x2 and 0x1, resp 1, in order. Without CALC2_SHIFT_EN both return resp 2, data 0.
- All four ports issue add in the same cycle with tags 0..3 → responses on ports 1, 2, 3, 4 in consecutive cycles, each with correct sum and tag.
- Cmd 0xF on port 1 → resp 2, data 0. Reset pulled low during a pending request → all outputs 0, no response after release.
